ble_rx_byte_buffer: RTL

Byte buffer between the UART receiver and the BLE connection monitor / command parsers.
- Captures received bytes into a small FIFO and drops framing-error bytes.
- Presents stored bytes through the valid / request / ready handshake the connection monitor uses (ack_valid, get_ack_byte, ack_ready).
- Reports FIFO level, sticky overflow and a line-idle pulse, so higher layers can resynchronise between BLE module responses.

---
 rtl/ble_pkg.sv | 16 +
 rtl/ble_sync_fifo.sv | 70 +++++++
 rtl/ble_rx_byte_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ble_pkg.sv
// rtl/ble_pkg.sv - shared BLE link-layer types and constants
package ble_pkg;

    typedef enum logic {
        RD_IDLE    = 1'b0,
        RD_PRESENT = 1'b1
    } rd_state_t;

    localparam int BLE_RX_DEPTH_DEFAULT = 16;

    // Framing characters used by the connection monitor and response parsers
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_COLON = 8'h3A;

endpackage

// File: rtl/ble_sync_fifo.sv
// rtl/ble_sync_fifo.sv - synchronous FIFO with flush and simultaneous push/pop
module ble_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wr_data_i,
    output logic [W-1:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [$clog2(DEPTH):0]     level_d_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign rd_data_o = mem[rd_ptr_q];

    // When full, a push is only legal if a pop frees the slot in the same cycle
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/ble_rx_byte_buffer.sv
// rtl/ble_rx_byte_buffer.sv - UART byte buffer with ack handshake, error count and idle detect
module ble_rx_byte_buffer
    import ble_pkg::*;
#(
    parameter int DEPTH  = BLE_RX_DEPTH_DEFAULT,
    parameter int IDLE_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_frame_err,
    input  logic                     flush,
    input  logic                     clear_overflow,
    input  logic [IDLE_W-1:0]        idle_time_count,
    input  logic                     get_ack_byte,
    output logic [7:0]               ack_byte,
    output logic                     ack_valid,
    output logic                     ack_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               frame_err_cnt,
    output logic                     line_idle
);

    localparam int LW = $clog2(DEPTH) + 1;

    rd_state_t         state_q;
    logic [7:0]        ack_byte_q;
    logic              ack_valid_q, ack_ready_q;
    logic              overflow_q, overflow_d;
    logic [7:0]        frame_err_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              line_idle_q, line_idle_d;
    logic              idle_inc;

    logic [7:0]        fifo_rd_data;
    logic [LW-1:0]     fifo_level, fifo_level_d;
    logic              fifo_full, fifo_empty;
    logic              byte_ok, pop_req, ovf_event;

    assign byte_ok = rx_valid && !rx_frame_err;
    assign pop_req = (state_q == RD_IDLE) && get_ack_byte && !fifo_empty && !flush;

    // A full FIFO only loses the byte when nothing is popped in the same cycle
    assign ovf_event = byte_ok && fifo_full && !pop_req && !flush;

    ble_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .push_i    (byte_ok),
        .pop_i     (pop_req),
        .wr_data_i (rx_data),
        .rd_data_o (fifo_rd_data),
        .level_o   (fifo_level),
        .level_d_o (fifo_level_d),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_event)           overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    // Counter freezes once it reaches the threshold, so line_idle fires once per quiet gap
    assign idle_inc    = !rx_valid && (idle_cnt_q < idle_time_count);
    assign line_idle_d = idle_inc && (idle_cnt_q + IDLE_W'(1) == idle_time_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RD_IDLE;
            ack_byte_q  <= 8'h00;
            ack_valid_q <= 1'b0;
            ack_ready_q <= 1'b0;
        end else if (flush) begin
            state_q     <= RD_IDLE;
            ack_valid_q <= 1'b0;
            ack_ready_q <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (pop_req) begin
                        ack_byte_q  <= fifo_rd_data;
                        ack_ready_q <= 1'b1;
                        ack_valid_q <= 1'b0;
                        state_q     <= RD_PRESENT;
                    end else begin
                        ack_ready_q <= 1'b0;
                        ack_valid_q <= (fifo_level_d != '0);
                    end
                end
                RD_PRESENT: begin
                    ack_ready_q <= 1'b0;
                    ack_valid_q <= (fifo_level_d != '0);
                    state_q     <= RD_IDLE;
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q      <= 1'b0;
            frame_err_cnt_q <= 8'h00;
            idle_cnt_q      <= '0;
            line_idle_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            if (rx_valid && rx_frame_err && (frame_err_cnt_q != 8'hFF))
                frame_err_cnt_q <= frame_err_cnt_q + 8'h01;
            if (rx_valid)      idle_cnt_q <= '0;
            else if (idle_inc) idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            line_idle_q <= line_idle_d;
        end
    end

    assign ack_byte      = ack_byte_q;
    assign ack_valid     = ack_valid_q;
    assign ack_ready     = ack_ready_q;
    assign level         = fifo_level;
    assign overflow      = overflow_q;
    assign frame_err_cnt = frame_err_cnt_q;
    assign line_idle     = line_idle_q;

endmodule
